// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan/direct channel sampler.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_mux_reg_mux_nto1.sv
// Combinational NCH:1 selector of W-bit channels; zero latency, no flow control.
// Indices at or beyond NCH select nothing and yield zero.
module mux_nto1 #(
  parameter int NCH  = 16,
  parameter int W    = 1,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH*W-1:0] data,
  input  logic [SELW-1:0]  idx,
  output logic [W-1:0]     out
);

  always_comb begin
    out = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx == SELW'(k)) out = data[k*W +: W];
    end
  end

endmodule

// File: rtl/scan_mux_reg.sv
// Registered NCH:1 sampler, DIRECT or auto-SCAN; 1-cycle latency, holds on stall (valid & !ready).
// Optional dout_par output when SCAN_MUX_PARITY_EN is defined.
module scan_mux_reg
  import scan_mux_pkg::*;
#(
  parameter int NCH = 16,
  parameter int W   = 1,
  localparam int SELW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] data_in,
  input  logic             mode,
  input  logic             en,
  input  logic [SELW-1:0]  sel,
  output logic [W-1:0]     dout,
  output logic [SELW-1:0]  dout_ch,
  output logic             dout_valid,
  input  logic             dout_ready,
`ifdef SCAN_MUX_PARITY_EN
  output logic             dout_par,
`endif
  output logic             wrap,
  output logic             sel_err
);

  localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

  state_t          state, nxt;
  logic            slot_free, scan_ld, in_range;
  logic [SELW-1:0] cnt, idx;
  logic [W-1:0]    mux_out;

  assign slot_free = !dout_valid || dout_ready;
  assign scan_ld   = (nxt == SCAN);
  assign idx       = scan_ld ? cnt : sel;
  assign in_range  = (32'(idx) < 32'(NCH));

  always_comb begin
    nxt = state;
    case (state)
      IDLE:         if (en) nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;
      DIRECT, SCAN: nxt = !en ? IDLE : ((mode == MODE_SCAN) ? SCAN : DIRECT);
      default:      nxt = IDLE;
    endcase
  end

  mux_nto1 #(.NCH(NCH), .W(W), .SELW(SELW)) u_mux (
    .data (data_in),
    .idx  (idx),
    .out  (mux_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      wrap       <= 1'b0;
      sel_err    <= 1'b0;
`ifdef SCAN_MUX_PARITY_EN
      dout_par   <= 1'b0;
`endif
    end else begin
      wrap    <= 1'b0;
      sel_err <= 1'b0;
      // Nothing moves while a sample is waiting to be consumed.
      if (slot_free) begin
        state      <= nxt;
        dout_valid <= (nxt != IDLE);
        if (nxt != IDLE) begin
          dout    <= mux_out;
          dout_ch <= idx;
`ifdef SCAN_MUX_PARITY_EN
          dout_par <= ^mux_out;
`endif
          if (scan_ld) begin
            wrap <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + SELW'(1);
          end else begin
            sel_err <= !in_range;
          end
        end
      end
    end
  end

endmodule
